// File: rtl/blake_msg_sched.sv
// BLAKE-512 message/constant scheduler: captures a 16-word message block, then
// streams one registered operand set per G call (NROUNDS rounds x 8 calls).
module blake_msg_sched #(
    parameter int NROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [63:0] msg_data,
    output logic        g_valid,
    input  logic        g_ready,
    output logic [63:0] g_m0,
    output logic [63:0] g_m1,
    output logic [63:0] g_k0,
    output logic [63:0] g_k1,
    output logic [2:0]  g_idx,
    output logic [3:0]  g_round,
    output logic        g_last,
    output logic        done
);
    typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_DONE} state_t;

    localparam logic [3:0] LAST_R = 4'(NROUNDS - 1);

    localparam logic [63:0] C [16] = '{
        64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
        64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
        64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
        64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
    };

    localparam int SIGMA [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };

    state_t      state_q, state_d;
    logic [3:0]  w_q;
    logic [3:0]  r_q, r_d, sig_row;
    logic [2:0]  i_q, i_d;
    logic [3:0]  s0, s1;
    logic        adv, g_last_q;
    logic [63:0] m0_q, m1_q, k0_q, k1_q;
    logic [63:0] msg_mem [16];
    logic        msg_fire, g_fire, load_done;

    assign msg_fire  = msg_valid & msg_ready;
    assign g_fire    = g_valid & g_ready;
    assign load_done = msg_fire & (w_q == 4'd15);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_LOAD;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD:  if (load_done)          state_d = S_ISSUE;
            S_ISSUE: if (g_fire && g_last_q) state_d = S_DONE;
            S_DONE:                          state_d = S_LOAD;
            default:                         state_d = S_LOAD;
        endcase
        if (abort) state_d = S_LOAD;
    end

    always_comb begin
        msg_ready = (state_q == S_LOAD);
        g_valid   = (state_q == S_ISSUE);
        done      = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          w_q <= 4'd0;
        else if (abort || state_q == S_DONE) w_q <= 4'd0;
        else if (msg_fire)                   w_q <= w_q + 4'd1;
    end

    // NOTE: the message RAM has no reset; its contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (msg_fire && !abort) msg_mem[w_q] <= msg_data;
    end

    // Next (r,i) to present; the first set only needs m[0], m[1], already stored.
    always_comb begin
        r_d = r_q;
        i_d = i_q;
        adv = 1'b0;
        if (load_done) begin
            r_d = 4'd0;
            i_d = 3'd0;
            adv = 1'b1;
        end else if (g_fire && !g_last_q) begin
            i_d = i_q + 3'd1;
            if (i_q == 3'd7) r_d = r_q + 4'd1;
            adv = 1'b1;
        end
        if (abort) adv = 1'b0;
        sig_row = (r_d >= 4'd10) ? r_d - 4'd10 : r_d;
        s0      = 4'(SIGMA[sig_row][{i_d, 1'b0}]);
        s1      = 4'(SIGMA[sig_row][{i_d, 1'b1}]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= 4'd0;
            i_q      <= 3'd0;
            m0_q     <= 64'd0;
            m1_q     <= 64'd0;
            k0_q     <= 64'd0;
            k1_q     <= 64'd0;
            g_last_q <= 1'b0;
        end else if (abort) begin
            g_last_q <= 1'b0;
        end else if (adv) begin
            r_q      <= r_d;
            i_q      <= i_d;
            m0_q     <= msg_mem[s0];
            m1_q     <= msg_mem[s1];
            k0_q     <= C[s0];
            k1_q     <= C[s1];
            g_last_q <= (r_d == LAST_R) && (i_d == 3'd7);
        end else if (g_fire) begin
            g_last_q <= 1'b0;
        end
    end

    assign g_m0    = m0_q;
    assign g_m1    = m1_q;
    assign g_k0    = k0_q;
    assign g_k1    = k1_q;
    assign g_idx   = i_q;
    assign g_round = r_q;
    assign g_last  = g_last_q;

endmodule

// File: tb/tb_blake_msg_sched.sv
// Scoreboard bench for blake_msg_sched: stimulus pushes expected operand sets,
// a negedge monitor pops and compares on every accepted set.
module tb_blake_msg_sched;
    localparam int NR    = 16;
    localparam int NSETS = NR * 8;

    localparam logic [63:0] CK [16] = '{
        64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
        64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
        64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
        64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69
    };

    localparam int SIG [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };

    typedef struct packed {
        logic [63:0] m0, m1, k0, k1;
        logic [3:0]  rnd;
        logic [2:0]  idx;
        logic        last;
    } set_t;

    logic        clk = 1'b0;
    logic        rst_n, abort, msg_valid, msg_ready, g_valid, g_ready, g_last, done;
    logic [63:0] msg_data, g_m0, g_m1, g_k0, g_k1;
    logic [2:0]  g_idx;
    logic [3:0]  g_round;

    set_t        sb[$];
    set_t        seen[$];
    logic [63:0] blk [16];
    int tests = 0, fails = 0;
    int cyc = 0, first_cyc = 0, last_cyc = 0, done_cnt = 0;

    blake_msg_sched #(.NROUNDS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .abort(abort),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .g_valid(g_valid), .g_ready(g_ready),
        .g_m0(g_m0), .g_m1(g_m1), .g_k0(g_k0), .g_k1(g_k1),
        .g_idx(g_idx), .g_round(g_round), .g_last(g_last), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_set(input string name, input set_t act, input set_t exp);
        check({name, ".m0"}, act.m0, exp.m0);
        check({name, ".m1"}, act.m1, exp.m1);
        check({name, ".k0"}, act.k0, exp.k0);
        check({name, ".k1"}, act.k1, exp.k1);
        check({name, ".r_i_last"}, 64'({act.rnd, act.idx, act.last}), 64'({exp.rnd, exp.idx, exp.last}));
    endtask

    function automatic set_t model(input int r, input int i);
        set_t s;
        int a, b;
        a      = SIG[r % 10][2 * i];
        b      = SIG[r % 10][2 * i + 1];
        s.m0   = blk[a];
        s.m1   = blk[b];
        s.k0   = CK[a];
        s.k1   = CK[b];
        s.rnd  = 4'(r);
        s.idx  = 3'(i);
        s.last = (r == NR - 1) && (i == 7);
        return s;
    endfunction

    // Monitor: compares each accepted set, and checks stability across stalls.
    set_t cur, held;
    bit   holding = 1'b0;
    always @(negedge clk) begin
        cur = {g_m0, g_m1, g_k0, g_k1, g_round, g_idx, g_last};
        if (!rst_n || abort) begin
            holding = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                check("done_latency", 64'(cyc), 64'(last_cyc + 1));
            end
            if (g_valid) begin
                if (holding) check_set("stall_hold", cur, held);
                if (g_ready) begin
                    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) check_set("set", cur, sb.pop_front());
                    if (seen.size() == 0) first_cyc = cyc;
                    seen.push_back(cur);
                    if (cur.last) last_cyc = cyc;
                    holding = 1'b0;
                end else begin
                    held    = cur;
                    holding = 1'b1;
                end
            end else begin
                holding = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [63:0] base);
        for (int j = 0; j < 16; j++) blk[j] = base | 64'(j);
    endtask

    task automatic load_block(input int gap);
        seen.delete();
        for (int r = 0; r < NR; r++)
            for (int i = 0; i < 8; i++) sb.push_back(model(r, i));
        for (int j = 0; j < 16; j++) begin
            for (int g = 0; g < gap; g++) begin
                msg_valid = 1'b0;
                tick();
                check("ready_idle_load", 64'(msg_ready), 64'd1);
            end
            msg_valid = 1'b1;
            msg_data  = blk[j];
            check("ready_load", 64'(msg_ready), 64'd1);
            check("gvalid_load", 64'(g_valid), 64'd0);
            tick();
        end
        msg_valid = 1'b0;
        check("issue_latency", 64'(g_valid), 64'd1);
    endtask

    task automatic drain(input int stall_pct, input bit junk);
        int budget = 4000;
        int d0     = done_cnt;
        int k      = 0;
        while (done_cnt == d0 && budget > 0) begin
            g_ready   = ($urandom_range(99) >= stall_pct);
            msg_valid = junk && (k < 20);
            msg_data  = 64'hDEAD_BEEF_0000_0000 | 64'(k);
            tick();
            budget--;
            k++;
        end
        msg_valid = 1'b0;
        g_ready   = 1'b1;
        check("done_seen", 64'(done_cnt - d0), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);
        check("set_count", 64'(seen.size()), 64'(NSETS));
        check("done_one_cycle", 64'(done), 64'd0);
        check("ready_after_done", 64'(msg_ready), 64'd1);
    endtask

    task automatic reset_pulse_check();
        #2 rst_n = 1'b0;
        #1;
        check("rst_msg_ready", 64'(msg_ready), 64'd1);
        check("rst_g_valid", 64'(g_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_m0", g_m0, 64'd0);
        check("rst_m1", g_m1, 64'd0);
        check("rst_k0", g_k0, 64'd0);
        check("rst_k1", g_k1, 64'd0);
        check("rst_r_i_last", 64'({g_round, g_idx, g_last}), 64'd0);
        sb.delete();
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        bit reached;
        int d0;
        rst_n = 1'b0; abort = 1'b0; msg_valid = 1'b0; msg_data = 64'd0; g_ready = 1'b0;
        #12;
        check("reset_msg_ready", 64'(msg_ready), 64'd1);
        check("reset_g_valid", 64'(g_valid), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_m0", g_m0, 64'd0);
        check("reset_r_i_last", 64'({g_round, g_idx, g_last}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Tests 1 and 2: m[j]=j, no stalls, hand-computed spot values.
        fill(64'd0);
        g_ready = 1'b1;
        load_block(0);
        drain(0, 1'b0);
        check("consecutive_sets", 64'(last_cyc - first_cyc), 64'd127);
        if (seen.size() == NSETS) begin
            check("r0i0_m0", seen[0].m0, 64'd0);
            check("r0i0_m1", seen[0].m1, 64'd1);
            check("r0i0_k0", seen[0].k0, 64'h243F6A8885A308D3);
            check("r0i0_k1", seen[0].k1, 64'h13198A2E03707344);
            check("r1i0_m0", seen[8].m0, 64'd14);
            check("r1i0_m1", seen[8].m1, 64'd10);
            check("r1i0_k0", seen[8].k0, 64'h0801F2E2858EFC16);
            check("r1i0_k1", seen[8].k1, 64'h2FFD72DBD01ADFB7);
            check("r10i0_m0", seen[80].m0, 64'd0);
            check("r10i0_m1", seen[80].m1, 64'd1);
            check("last_on_128", 64'(seen[127].last), 64'd1);
            check("last_not_127", 64'(seen[126].last), 64'd0);
        end

        // Test 3: random downstream stalls.
        fill(64'hA5A5_0000_5A5A_0000);
        load_block(0);
        drain(40, 1'b0);

        // Test 4: gapped load, junk msg_valid during issue.
        fill(64'h1234_5678_0000_0000);
        load_block(2);
        drain(0, 1'b1);

        // Test 5: abort at r3 i5 during a handshake.
        fill(64'h0F0F_0000_0000_0000);
        load_block(0);
        budget  = 200;
        reached = 1'b0;
        while (!reached && budget > 0) begin
            if (g_valid && g_round == 4'd3 && g_idx == 3'd5) reached = 1'b1;
            else begin tick(); budget--; end
        end
        check("abort_point_reached", 64'(reached), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_g_valid", 64'(g_valid), 64'd0);
        check("abort_msg_ready", 64'(msg_ready), 64'd1);
        check("abort_done", 64'(done), 64'd0);
        sb.delete();
        d0 = done_cnt;
        repeat (5) tick();
        check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
        fill(64'h7777_0000_0000_0000);
        load_block(0);
        check("restart_r_i", 64'({g_round, g_idx}), 64'd0);
        drain(0, 1'b0);

        // Test 6: reset mid-load (w=7) and mid-issue, then a clean block.
        for (int j = 0; j < 7; j++) begin
            msg_valid = 1'b1;
            msg_data  = 64'hBAD0_0000_0000_0000 | 64'(j);
            tick();
        end
        msg_valid = 1'b0;
        reset_pulse_check();
        fill(64'hC0DE_0000_0000_0000);
        load_block(0);
        repeat (40) tick();
        reset_pulse_check();
        fill(64'd0);
        load_block(0);
        drain(0, 1'b0);
        check("post_reset_consecutive", 64'(last_cyc - first_cyc), 64'd127);
        if (seen.size() == NSETS) begin
            check("post_reset_r1i0_m0", seen[8].m0, 64'd14);
            check("post_reset_r1i0_m1", seen[8].m1, 64'd10);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
